rx_ltssm: RTL and testbench

- Receive-side companion to the TX LTSSM in the PCIe PHY.
- Watches the decoded ordered-set stream from the OS decoder/lane aggregator and counts consecutive qualifying TS1/TS2/IDLE receptions for the state set by the main LTSSM.
- Reports the required exit (RXFinishFlag/RXExitTo) back to the main LTSSM.
- Upstream devices learn the link number from received TS1s and write it to the main LTSSM link-number register.

---
 rtl/ltssm_pkg.sv | 41 ++++
 rtl/rx_ltssm_if.sv | 23 ++
 rtl/rx_os_counter.sv | 34 +++
 rtl/rx_ltssm.sv | 186 ++++++++++++++++++
 tb/tb_rx_ltssm.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: state encodings (common with the TX LTSSM), ordered-set
// type codes, the PAD symbol and the consecutive-set counts needed to leave each state.
package ltssm_pkg;

  typedef enum logic [3:0] {
    ST_DETECT_QUIET   = 4'd0,
    ST_DETECT_ACTIVE  = 4'd1,
    ST_POLLING_ACTIVE = 4'd2,
    ST_POLLING_CONFIG = 4'd3,
    ST_CFG_LW_START   = 4'd4,
    ST_CFG_LW_ACCEPT  = 4'd5,
    ST_CFG_LN_WAIT    = 4'd6,
    ST_CFG_LN_ACTIVE  = 4'd7,
    ST_CFG_COMPLETE   = 4'd8,
    ST_CFG_IDLE       = 4'd9,
    ST_L0             = 4'd10,
    ST_IDLE           = 4'd15
  } ltssm_state_e;

  typedef enum logic [2:0] {
    OS_TS1  = 3'b000,
    OS_TS2  = 3'b001,
    OS_IDLE = 3'b100
  } os_type_e;

  localparam logic [7:0] PAD_SYM = 8'hF7;

  localparam int N_POLL_ACTIVE   = 8;
  localparam int N_POLL_CONFIG   = 8;
  localparam int N_CFG_LW_START  = 2;
  localparam int N_CFG_LW_ACCEPT = 2;
  localparam int N_CFG_LANE_NUM  = 2;
  localparam int N_CFG_COMPLETE  = 8;
  localparam int N_CFG_IDLE      = 8;

  // Polling and Configuration substates are the ones that train on received sets.
  function automatic logic is_training(ltssm_state_e s);
    return (s >= ST_POLLING_ACTIVE) && (s <= ST_CFG_IDLE);
  endfunction

endpackage

// File: rtl/rx_ltssm_if.sv
// Bundle between the OS decoder / main LTSSM (master) and the receive LTSSM (slave).
interface rx_ltssm_if;
  logic [3:0] SetRXState;
  logic       OSValid;
  logic [2:0] OSType;
  logic [7:0] OSLinkNum;
  logic [7:0] OSLaneNum;
  logic [7:0] ReadLinkNum;
  logic       RXFinishFlag;
  logic [3:0] RXExitTo;
  logic [7:0] WriteLinkNum;
  logic       WriteLinkNumFlag;

  modport master (
    output SetRXState, OSValid, OSType, OSLinkNum, OSLaneNum, ReadLinkNum,
    input  RXFinishFlag, RXExitTo, WriteLinkNum, WriteLinkNumFlag
  );

  modport slave (
    input  SetRXState, OSValid, OSType, OSLinkNum, OSLaneNum, ReadLinkNum,
    output RXFinishFlag, RXExitTo, WriteLinkNum, WriteLinkNumFlag
  );
endinterface

// File: rtl/rx_os_counter.sv
// Saturating consecutive-match counter. A mismatch that arrives together with inc
// restarts the run at 1 (the current set begins a new run).
module rx_os_counter #(
  parameter int CNT_W = 4
) (
  input  logic             Pclk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             inc,
  input  logic             mismatch,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (mismatch) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rx_ltssm.sv
// Receive-side LTSSM: counts consecutive qualifying TS1/TS2/IDLE sets for the state
// commanded by the main LTSSM and pulses the exit. Option: LTSSM_RX_TIMEOUT_EN.
module rx_ltssm #(
  parameter int         DEVICETYPE     = 0,
  parameter logic [7:0] PAD_SYM        = ltssm_pkg::PAD_SYM,
  parameter int         TIMEOUT_CYCLES = 24000,
  parameter int         CNT_W          = 4
) (
  input  logic       Pclk,
  input  logic       Reset,
  rx_ltssm_if.slave  bus
);
  import ltssm_pkg::*;

  localparam bit UPSTREAM = (DEVICETYPE == 1);

  ltssm_state_e     state_q, state_d;
  logic             state_chg;
  logic             has_rule, match, restart, learn;
  logic [CNT_W-1:0] need_m1;
  ltssm_state_e     target;
  logic             os_eval, cnt_clear, cnt_inc, cnt_mismatch;
  logic [CNT_W-1:0] cnt;
  logic             hit, timeout_hit;
  logic [7:0]       prev_link_q, prev_link_d;
  logic             prev_vld_q, prev_vld_d;
  logic             finish_q, finish_d;
  ltssm_state_e     exit_to_q, exit_to_d;
  logic [7:0]       wlink_q, wlink_d;
  logic             wflag_q, wflag_d;

  assign state_d   = ltssm_state_e'(bus.SetRXState);
  assign state_chg = (bus.SetRXState != state_q);

  always_comb begin
    has_rule = 1'b0;
    match    = 1'b0;
    restart  = 1'b0;
    learn    = 1'b0;
    need_m1  = '0;
    target   = ST_DETECT_QUIET;
    unique case (state_q)
      ST_POLLING_ACTIVE: begin
        has_rule = 1'b1;
        match    = ((bus.OSType == OS_TS1) || (bus.OSType == OS_TS2)) &&
                   (bus.OSLinkNum == PAD_SYM) && (bus.OSLaneNum == PAD_SYM);
        need_m1  = CNT_W'(N_POLL_ACTIVE - 1);
        target   = ST_POLLING_CONFIG;
      end
      ST_POLLING_CONFIG: begin
        has_rule = 1'b1;
        match    = (bus.OSType == OS_TS2) &&
                   (bus.OSLinkNum == PAD_SYM) && (bus.OSLaneNum == PAD_SYM);
        need_m1  = CNT_W'(N_POLL_CONFIG - 1);
        target   = ST_CFG_LW_START;
      end
      ST_CFG_LW_START: begin
        has_rule = 1'b1;
        need_m1  = CNT_W'(N_CFG_LW_START - 1);
        target   = ST_CFG_LW_ACCEPT;
        if (UPSTREAM) begin
          // Upstream ports adopt whatever non-PAD link number the partner proposes,
          // but only once it has been stable across the whole run.
          match   = (bus.OSType == OS_TS1) && (bus.OSLinkNum != PAD_SYM);
          restart = match && prev_vld_q && (bus.OSLinkNum != prev_link_q);
          learn   = 1'b1;
        end else begin
          match   = (bus.OSType == OS_TS1) && (bus.OSLinkNum == bus.ReadLinkNum);
        end
      end
      ST_CFG_LW_ACCEPT: begin
        has_rule = 1'b1;
        match    = (bus.OSType == OS_TS1) && (bus.OSLinkNum == bus.ReadLinkNum) &&
                   (bus.OSLaneNum != PAD_SYM);
        need_m1  = CNT_W'(N_CFG_LW_ACCEPT - 1);
        target   = ST_CFG_LN_WAIT;
      end
      ST_CFG_LN_WAIT, ST_CFG_LN_ACTIVE: begin
        has_rule = 1'b1;
        match    = (bus.OSType == OS_TS2) && (bus.OSLinkNum == bus.ReadLinkNum);
        need_m1  = CNT_W'(N_CFG_LANE_NUM - 1);
        target   = ST_CFG_COMPLETE;
      end
      ST_CFG_COMPLETE: begin
        has_rule = 1'b1;
        match    = (bus.OSType == OS_TS2) && (bus.OSLinkNum == bus.ReadLinkNum);
        need_m1  = CNT_W'(N_CFG_COMPLETE - 1);
        target   = ST_CFG_IDLE;
      end
      ST_CFG_IDLE: begin
        has_rule = 1'b1;
        match    = (bus.OSType == OS_IDLE);
        need_m1  = CNT_W'(N_CFG_IDLE - 1);
        target   = ST_L0;
      end
      default: ;
    endcase
  end

  // A state change in the same cycle as OSValid wins: the set is dropped.
  assign os_eval      = bus.OSValid && !state_chg && has_rule;
  assign cnt_clear    = state_chg || !has_rule;
  assign cnt_inc      = os_eval && match;
  assign cnt_mismatch = os_eval && (!match || restart);
  assign hit          = cnt_inc && !restart && (cnt == need_m1);

  rx_os_counter #(.CNT_W(CNT_W)) u_cnt (
    .Pclk     (Pclk),
    .Reset    (Reset),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .mismatch (cnt_mismatch),
    .cnt      (cnt)
  );

  always_comb begin
    prev_link_d = prev_link_q;
    prev_vld_d  = prev_vld_q;
    if (cnt_clear) begin
      prev_vld_d = 1'b0;
    end else if (os_eval && (bus.OSType == OS_TS1)) begin
      prev_link_d = bus.OSLinkNum;
      prev_vld_d  = 1'b1;
    end
  end

`ifdef LTSSM_RX_TIMEOUT_EN
  localparam int              TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Timer parks at TMR_END after firing so the timeout pulses only once per state.
  always_comb begin
    timer_d     = timer_q;
    timeout_hit = 1'b0;
    if (state_chg || !is_training(state_q) || cnt_inc) begin
      timer_d = '0;
    end else if (timer_q != TMR_END) begin
      timer_d     = timer_q + 1'b1;
      timeout_hit = (timer_d == TMR_END);
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  // No timer in this build; the comparison is constant-false for any legal setting.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    finish_d  = hit || timeout_hit;
    exit_to_d = hit ? target : ST_DETECT_QUIET;
    wflag_d   = hit && learn;
    wlink_d   = wflag_d ? bus.OSLinkNum : wlink_q;
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      prev_link_q <= '0;
      prev_vld_q  <= 1'b0;
      finish_q    <= 1'b0;
      exit_to_q   <= ST_DETECT_QUIET;
      wlink_q     <= '0;
      wflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_link_q <= prev_link_d;
      prev_vld_q  <= prev_vld_d;
      finish_q    <= finish_d;
      exit_to_q   <= exit_to_d;
      wlink_q     <= wlink_d;
      wflag_q     <= wflag_d;
    end
  end

  assign bus.RXFinishFlag     = finish_q;
  assign bus.RXExitTo         = exit_to_q;
  assign bus.WriteLinkNum     = wlink_q;
  assign bus.WriteLinkNumFlag = wflag_q;

endmodule

// File: tb/tb_rx_ltssm.sv
// Bench for rx_ltssm: a downstream and an upstream instance share one stimulus stream
// and are checked against a per-device reference model, a vector table and directed runs.
module tb_rx_ltssm;
  import ltssm_pkg::*;

  localparam int TOUT = 100;
  localparam int PAD  = 247;

  logic       Pclk = 1'b0;
  logic       rst_n;
  logic [3:0] set_st;
  logic       os_v;
  logic [2:0] os_t;
  logic [7:0] os_l, os_ln, rlink;

  always #5 Pclk = ~Pclk;

  rx_ltssm_if bus_dn ();
  rx_ltssm_if bus_up ();

  assign bus_dn.SetRXState  = set_st;
  assign bus_dn.OSValid     = os_v;
  assign bus_dn.OSType      = os_t;
  assign bus_dn.OSLinkNum   = os_l;
  assign bus_dn.OSLaneNum   = os_ln;
  assign bus_dn.ReadLinkNum = rlink;
  assign bus_up.SetRXState  = set_st;
  assign bus_up.OSValid     = os_v;
  assign bus_up.OSType      = os_t;
  assign bus_up.OSLinkNum   = os_l;
  assign bus_up.OSLaneNum   = os_ln;
  assign bus_up.ReadLinkNum = rlink;

  rx_ltssm #(.DEVICETYPE(0), .TIMEOUT_CYCLES(TOUT)) dut_dn (
    .Pclk(Pclk), .Reset(rst_n), .bus(bus_dn.slave));
  rx_ltssm #(.DEVICETYPE(1), .TIMEOUT_CYCLES(TOUT)) dut_up (
    .Pclk(Pclk), .Reset(rst_n), .bus(bus_up.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: run length of consecutive qualifying sets per device.
  int m_state[2], m_run[2], m_prev[2], m_timer[2];
  bit e_flag[2], e_wf[2];
  int e_exit[2], e_wl[2];
  int seen[2];

  function automatic int need_of(int s);
    case (s)
      2, 3, 8, 9:    return 8;
      4, 5, 6, 7:    return 2;
      default:       return 0;
    endcase
  endfunction

  function automatic int target_of(int s);
    case (s)
      2: return 3;  3: return 4;  4: return 5;  5: return 6;
      6, 7: return 8;  8: return 9;  9: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic bit good(int dev, int s, int t, int l, int ln, int rl);
    case (s)
      2: return (t == 0 || t == 1) && l == PAD && ln == PAD;
      3: return t == 1 && l == PAD && ln == PAD;
      4: return (dev == 1) ? (t == 0 && l != PAD) : (t == 0 && l == rl);
      5: return t == 0 && l == rl && ln != PAD;
      6, 7, 8: return t == 1 && l == rl;
      9: return t == 4;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit q;
      int n;
      e_flag[d] = 0; e_wf[d] = 0; e_exit[d] = 0;
      if (!rst_n) begin
        m_state[d] = 15; m_run[d] = 0; m_prev[d] = -1; m_timer[d] = 0; e_wl[d] = 0;
        continue;
      end
      if (int'(set_st) != m_state[d]) begin
        m_state[d] = int'(set_st); m_run[d] = 0; m_prev[d] = -1; m_timer[d] = 0;
        continue;
      end
      n = need_of(m_state[d]);
      if (n == 0) continue;
      q = 0;
      if (os_v) begin
        q = good(d, m_state[d], int'(os_t), int'(os_l), int'(os_ln), int'(rlink));
        if (q) m_run[d] = (d == 1 && m_state[d] == 4 && m_prev[d] >= 0 && int'(os_l) != m_prev[d])
                          ? 1 : m_run[d] + 1;
        else   m_run[d] = 0;
        if (os_t == 3'b000) m_prev[d] = int'(os_l);
        if (q && m_run[d] == n) begin
          e_flag[d] = 1; e_exit[d] = target_of(m_state[d]);
          if (d == 1 && m_state[d] == 4) begin e_wf[d] = 1; e_wl[d] = int'(os_l); end
        end
      end
`ifdef LTSSM_RX_TIMEOUT_EN
      if (q) m_timer[d] = 0;
      else if (m_timer[d] < TOUT) begin
        m_timer[d]++;
        if (m_timer[d] == TOUT && !e_flag[d]) begin e_flag[d] = 1; e_exit[d] = 0; end
      end
`endif
    end
  endtask

  task automatic step(input bit r, input int s, input int v, input int t,
                      input int l, input int ln, input int rl);
    rst_n = r; set_st = 4'(s); os_v = v[0]; os_t = 3'(t);
    os_l = 8'(l); os_ln = 8'(ln); rlink = 8'(rl);
    model_step();
    @(posedge Pclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      logic f, wf;
      logic [3:0] x;
      logic [7:0] wl;
      f  = d ? bus_up.RXFinishFlag     : bus_dn.RXFinishFlag;
      x  = d ? bus_up.RXExitTo         : bus_dn.RXExitTo;
      wf = d ? bus_up.WriteLinkNumFlag : bus_dn.WriteLinkNumFlag;
      wl = d ? bus_up.WriteLinkNum     : bus_dn.WriteLinkNum;
      chk($sformatf("flag_dev%0d", d), 32'(f), 32'(e_flag[d]));
      if (e_flag[d] || !r) chk($sformatf("exit_dev%0d", d), 32'(x), 32'(e_exit[d]));
      chk($sformatf("wflag_dev%0d", d), 32'(wf), 32'(e_wf[d]));
      if (e_wf[d] || !r) chk($sformatf("wlink_dev%0d", d), 32'(wl), 32'(e_wl[d]));
      if (f === 1'b1) seen[d]++;
    end
  endtask

  typedef struct {
    bit r; int s; int v; int t; int l; int ln; bit ef; int ex;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int fire_at;
    int st_list[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 15};
    int cur_s, cur_rl;

    // PollingActive: 8 PAD/PAD training sets with gaps, one TS2 mixed in.
    tbl.push_back('{0, 15, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 0, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 1, 1, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 1, 3});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 1, 0, PAD, PAD, 0, 0});
    tbl.push_back('{1, 2, 1, 0, 3, PAD, 0, 0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].t, tbl[i].l, tbl[i].ln, 0);
      chk($sformatf("tbl%0d_flag", i), 32'(bus_dn.RXFinishFlag), 32'(tbl[i].ef));
      if (tbl[i].ef) chk($sformatf("tbl%0d_exit", i), 32'(bus_dn.RXExitTo), 32'(tbl[i].ex));
    end

    // PollingConfiguration: 7 TS2, a TS1 breaks the run, then 8 more TS2.
    step(1, 3, 0, 0, 0, 0, 0);
    seen[0] = 0;
    for (int i = 0; i < 7; i++) step(1, 3, 1, 1, PAD, PAD, 0);
    step(1, 3, 1, 0, PAD, PAD, 0);
    for (int i = 0; i < 7; i++) step(1, 3, 1, 1, PAD, PAD, 0);
    chk("pcfg_no_early_flag", 32'(seen[0]), 0);
    step(1, 3, 1, 1, PAD, PAD, 0);
    chk("pcfg_flag", 32'(bus_dn.RXFinishFlag), 1);
    chk("pcfg_exit", 32'(bus_dn.RXExitTo), 4);

    // CfgLinkWidthStart: upstream sees link 5, 6, 6 and learns 6.
    step(1, 4, 0, 0, 0, 0, 6);
    seen[1] = 0;
    step(1, 4, 1, 0, 5, PAD, 6);
    step(1, 4, 1, 0, 6, PAD, 6);
    chk("up_lw_no_early_flag", 32'(seen[1]), 0);
    step(1, 4, 1, 0, 6, PAD, 6);
    chk("up_lw_flag", 32'(bus_up.RXFinishFlag), 1);
    chk("up_lw_exit", 32'(bus_up.RXExitTo), 5);
    chk("up_lw_wflag", 32'(bus_up.WriteLinkNumFlag), 1);
    chk("up_lw_wlink", 32'(bus_up.WriteLinkNum), 6);
    step(1, 4, 0, 0, 0, 0, 6);
    chk("up_lw_wflag_one_cycle", 32'(bus_up.WriteLinkNumFlag), 0);

    // CfgIdle interrupted by a move to DetectQuiet before the 8th IDLE.
    step(1, 9, 0, 0, 0, 0, 6);
    seen[0] = 0;
    for (int i = 0; i < 7; i++) step(1, 9, 1, 4, 0, 0, 6);
    step(1, 0, 1, 4, 0, 0, 6);
    step(1, 0, 1, 4, 0, 0, 6);
    step(1, 9, 1, 4, 0, 0, 6);
    step(1, 9, 1, 4, 0, 0, 6);
    chk("cfgidle_interrupted", 32'(seen[0]), 0);

    // Reset after 5 TS2 in CfgComplete discards the partial run.
    step(1, 8, 0, 0, 0, 0, 6);
    for (int i = 0; i < 5; i++) step(1, 8, 1, 1, 6, 0, 6);
    step(0, 8, 1, 1, 6, 0, 6);
    step(1, 8, 0, 0, 0, 0, 6);
    seen[0] = 0;
    for (int i = 0; i < 3; i++) step(1, 8, 1, 1, 6, 0, 6);
    chk("reset_discards", 32'(seen[0]), 0);
    for (int i = 0; i < 4; i++) step(1, 8, 1, 1, 6, 0, 6);
    step(1, 8, 1, 1, 6, 0, 6);
    chk("post_reset_flag", 32'(bus_dn.RXFinishFlag), 1);
    chk("post_reset_exit", 32'(bus_dn.RXExitTo), 9);

    // CfgComplete with no ordered sets at all.
    step(1, 7, 0, 0, 0, 0, 6);
    step(1, 8, 0, 0, 0, 0, 6);
    seen[0] = 0;
    fire_at = -1;
    for (int i = 1; i <= TOUT + 20; i++) begin
      step(1, 8, 0, 0, 0, 0, 6);
      if (bus_dn.RXFinishFlag === 1'b1 && fire_at < 0) fire_at = i;
    end
`ifdef LTSSM_RX_TIMEOUT_EN
    chk("timeout_count", 32'(seen[0]), 1);
    chk("timeout_cycle", 32'(fire_at), 32'(TOUT));
`else
    chk("no_timeout_count", 32'(seen[0]), 0);
`endif

    // Randomized traffic against the model; mostly well-formed sets for the state.
    cur_s = 2;
    cur_rl = 6;
    for (int i = 0; i < 4000; i++) begin
      int t, l, ln, v;
      bit r;
      r = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 39) == 0) cur_s = st_list[$urandom_range(0, 11)];
      if ($urandom_range(0, 199) == 0) cur_rl = ($urandom_range(0, 1) != 0) ? 6 : 9;
      v = ($urandom_range(0, 2) != 0) ? 1 : 0;
      t = 0; l = cur_rl; ln = 0;
      if ($urandom_range(0, 9) < 8) begin
        case (cur_s)
          2: begin t = $urandom_range(0, 1); l = PAD; ln = PAD; end
          3: begin t = 1; l = PAD; ln = PAD; end
          4: begin t = 0; l = ($urandom_range(0, 5) == 0) ? 5 : cur_rl; ln = PAD; end
          5: begin t = 0; ln = $urandom_range(0, 3); end
          6, 7, 8: t = 1;
          9: t = 4;
          default: t = $urandom_range(0, 7);
        endcase
      end else begin
        int tl[5] = '{0, 1, 4, 2, 7};
        t  = tl[$urandom_range(0, 4)];
        l  = ($urandom_range(0, 1) != 0) ? PAD : 5;
        ln = ($urandom_range(0, 1) != 0) ? PAD : 0;
      end
      step(r, cur_s, v, t, l, ln, cur_rl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
